dcm_lock_supervisor: RTL and testbench
======================================

Name: dcm_lock_supervisor

Overview:
- Control-side counterpart of the DCM clock generator. It drives the DCM RST input and consumes the DCM LOCKED and STATUS outputs, which are currently tied off.
- Runs on the raw board clock, before the DCM.
- Pulses DCM reset, waits for lock and qualifies it, and holds the downstream fabric in reset until the synthesized clock is trustworthy.
- Re-runs the sequence on lock loss or a clock-stop fault. Latches a permanent fault after too many consecutive failures.

Parameters:
- RST_CYCLES, 8, cycles DCM_RST is held high per attempt (DCM minimum is 3; legal range 3..255).
- LOCK_TIMEOUT, 50000, cycles to wait for lock before retrying (500 us at 100 MHz).
- STABLE_CYCLES, 256, consecutive clean locked cycles required before release.
- MAX_RETRIES, 7, consecutive failed attempts tolerated before FAULT (at most 15).
- CNT_W, 17, width of the shared cycle counter. Must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- CLK, input, 1: raw 100 MHz board clock.
- RST, input, 1: synchronous, active-high reset.
- LOCKED_IN, input, 1: DCM LOCKED; asynchronous to CLK.
- STATUS_IN, input, 8: DCM STATUS. Bit 1 = CLKIN stopped, bit 2 = CLKFX stopped; other bits ignored.
- DCM_RST, output, 1: to DCM RST.
- RST_OUT, output, 1: active-high reset for logic clocked by CLK_out / CLKSYS.
- CLK_READY, output, 1: synthesized clock qualified.
- FAULT, output, 1: supervisor gave up.
- RETRY_CNT, output, 4: consecutive failed attempts.

Interface rule: one clock (CLK); reset RST is synchronous and active-high.

Behaviour:
Input conditioning:
- LOCKED_IN, STATUS_IN[1] and STATUS_IN[2] each pass through a 2-flop synchronizer; the synchronizer flops reset to 0.
- lock_s = synchronized LOCKED. flt_s = synchronized STATUS[1] OR synchronized STATUS[2].
- Input-to-decision latency is 2 cycles.

Outputs:
- All outputs are Moore-decoded from the registered state, cnt and retry registers. No combinational path from any input.

States:
- RESET_DCM: DCM_RST=1, RST_OUT=1, CLK_READY=0.
  - cnt counts 0..RST_CYCLES-1.
  - When cnt==RST_CYCLES-1: go to WAIT_LOCK, cnt=0. DCM_RST is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK: DCM_RST=0, RST_OUT=1.
  - If lock_s && !flt_s: go to STABLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1: FAIL.
  - Else cnt++.
- STABLE: DCM_RST=0, RST_OUT=1.
  - If !lock_s || flt_s: FAIL.
  - Else if cnt==STABLE_CYCLES-1: go to RUN, RETRY_CNT=0.
  - Else cnt++.
- RUN: DCM_RST=0, RST_OUT=0, CLK_READY=1.
  - If !lock_s || flt_s: FAIL.
  - RST_OUT and DCM_RST assert together on the first cycle after the transition.
- FAULT: DCM_RST=0, RST_OUT=1, CLK_READY=0, FAULT=1.
  - Sticky; exits only via RST.

FAIL (transition rule, not a state):
- If RETRY_CNT==MAX_RETRIES: go to FAULT.
- Else RETRY_CNT++, go to RESET_DCM, cnt=0.

Reset:
- RST=1 forces state=RESET_DCM, cnt=0, RETRY_CNT=0 and synchronizers=0.
- Outputs during reset: DCM_RST=1, RST_OUT=1, CLK_READY=0, FAULT=0.
- RST asserted mid-operation (any state, including RUN and FAULT) takes effect on the next edge. Counting restarts from 0 after release.

Boundary conditions:
- Simultaneous lock and timeout in WAIT_LOCK: lock wins.
- flt_s alone, with lock_s=1, counts as loss.
- A lock glitch shorter than 1 cycle may be missed by the synchronizer; this is acceptable.
- Glitches during RESET_DCM are ignored.
- RETRY_CNT never exceeds MAX_RETRIES.

Timing reference:
- With lock_s already high, CLK_READY rises exactly RST_CYCLES+1+STABLE_CYCLES cycles after the first edge with RST=0.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. LOCKED_IN=1 and STATUS_IN=0 throughout reset, then release:
   - DCM_RST high for 4 cycles after release.
   - CLK_READY and RST_OUT toggle at cycle 13 and hold; RETRY_CNT=0.
2. LOCKED_IN held 0:
   - DCM_RST re-pulses every 4+20 cycles; RETRY_CNT steps 1, 2.
   - The third timeout gives FAULT=1, DCM_RST=0, RST_OUT=1.
   - RST then clears FAULT and RETRY_CNT.
3. In RUN, drop LOCKED_IN for 3 cycles:
   - 2 cycles later DCM_RST=1 and RST_OUT=1 (same cycle), CLK_READY=0, RETRY_CNT=1.
   - After relock, back in RUN with RETRY_CNT=0.
4. In STABLE at cnt=5, pulse STATUS_IN[2]=1 with LOCKED_IN=1:
   - Restarts at RESET_DCM; no CLK_READY pulse seen.
   - Setting STATUS_IN[0]=1 alone causes no effect.
5. LOCKED_IN rises on the same cycle WAIT_LOCK cnt reaches 19 (sync-aligned):
   - Enters STABLE, no retry.
6. Assert RST for 1 cycle while in RUN:
   - Next cycle DCM_RST=1, RST_OUT=1, CLK_READY=0.
   - Full 13-cycle sequence repeats.

Source files
------------

// File: rtl/dcm_lock_supervisor.sv
// dcm_lock_supervisor
// Drives the DCM reset input from the raw board clock. It watches LOCKED and STATUS,
// qualifies the lock, and keeps the fabric clocked by the synthesized clock in reset
// until that clock can be trusted. On lock loss or a clock-stop fault it restarts the
// DCM. After more than MAX_RETRIES consecutive failed attempts it latches FAULT.
//
// Ports:
//   CLK        raw board clock (before the DCM)
//   RST        synchronous, active-high reset
//   LOCKED_IN  DCM LOCKED, asynchronous to CLK
//   STATUS_IN  DCM STATUS; bit 1 = CLKIN stopped, bit 2 = CLKFX stopped
//   DCM_RST    to DCM RST
//   RST_OUT    active-high reset for logic on the synthesized clock
//   CLK_READY  synthesized clock qualified
//   FAULT      supervisor gave up; cleared only by RST
//   RETRY_CNT  consecutive failed attempts
module dcm_lock_supervisor #(
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned LOCK_TIMEOUT  = 50000,
   parameter int unsigned STABLE_CYCLES = 256,
   parameter int unsigned MAX_RETRIES   = 7,
   parameter int unsigned CNT_W         = 17
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       LOCKED_IN,
   input  logic [7:0] STATUS_IN,
   output logic       DCM_RST,
   output logic       RST_OUT,
   output logic       CLK_READY,
   output logic       FAULT,
   output logic [3:0] RETRY_CNT
);

   typedef enum logic [2:0] {
      StResetDcm,
      StWaitLock,
      StStable,
      StRun,
      StFault
   } state_e;

   localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RetryMax   = 4'(MAX_RETRIES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;

   // Two-flop synchronizers; index 1 is the synchronized value.
   logic [1:0] lock_sync_q;
   logic [1:0] clkin_stop_q;
   logic [1:0] clkfx_stop_q;

   logic lock_s;
   logic flt_s;
   logic do_fail;

   // Only the two clock-stop bits carry meaning for the supervisor.
   logic unused_status;
   assign unused_status = ^{STATUS_IN[7:3], STATUS_IN[0]};

   assign lock_s = lock_sync_q[1];
   assign flt_s  = clkin_stop_q[1] | clkfx_stop_q[1];

   always_ff @(posedge CLK) begin
      if (RST) begin
         lock_sync_q  <= 2'b00;
         clkin_stop_q <= 2'b00;
         clkfx_stop_q <= 2'b00;
      end else begin
         lock_sync_q  <= {lock_sync_q[0], LOCKED_IN};
         clkin_stop_q <= {clkin_stop_q[0], STATUS_IN[1]};
         clkfx_stop_q <= {clkfx_stop_q[0], STATUS_IN[2]};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StResetDcm;
         cnt_q   <= '0;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      do_fail = 1'b0;

      unique case (state_q)
         StResetDcm: begin
            // Lock/status inputs are deliberately ignored while the DCM is held in reset.
            if (cnt_q == RstLast) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StWaitLock: begin
            // Lock is tested before the timeout so a lock on the last cycle still wins.
            if (lock_s && !flt_s) begin
               state_d = StStable;
               cnt_d   = '0;
            end else if (cnt_q == LockLast) begin
               do_fail = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StStable: begin
            if (!lock_s || flt_s) begin
               do_fail = 1'b1;
            end else if (cnt_q == StableLast) begin
               state_d = StRun;
               retry_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StRun: begin
            if (!lock_s || flt_s) begin
               do_fail = 1'b1;
            end
         end
         StFault: begin
            // Sticky until RST.
         end
         default: begin
            state_d = StResetDcm;
            cnt_d   = '0;
         end
      endcase

      // Failed attempt: retry from a fresh DCM reset, or give up once the budget is spent.
      if (do_fail) begin
         if (retry_q == RetryMax) begin
            state_d = StFault;
         end else begin
            retry_d = retry_q + 4'd1;
            state_d = StResetDcm;
            cnt_d   = '0;
         end
      end
   end

   // Moore outputs: decoded from registered state only.
   always_comb begin
      DCM_RST   = (state_q == StResetDcm);
      RST_OUT   = (state_q != StRun);
      CLK_READY = (state_q == StRun);
      FAULT     = (state_q == StFault);
      RETRY_CNT = retry_q;
   end

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Scoreboard bench for dcm_lock_supervisor. Stimulus queues the expected output vector
// for a given cycle; a monitor pops and compares it on the falling edge of that cycle.
module tb_dcm_lock_supervisor;

   localparam int unsigned RC = 4;
   localparam int unsigned LT = 20;
   localparam int unsigned SC = 8;
   localparam int unsigned MR = 2;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       LOCKED_IN = 1'b0;
   logic [7:0] STATUS_IN = 8'h00;
   logic       DCM_RST;
   logic       RST_OUT;
   logic       CLK_READY;
   logic       FAULT;
   logic [3:0] RETRY_CNT;

   dcm_lock_supervisor #(
      .RST_CYCLES   (RC),
      .LOCK_TIMEOUT (LT),
      .STABLE_CYCLES(SC),
      .MAX_RETRIES  (MR),
      .CNT_W        (17)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .LOCKED_IN(LOCKED_IN),
      .STATUS_IN(STATUS_IN),
      .DCM_RST  (DCM_RST),
      .RST_OUT  (RST_OUT),
      .CLK_READY(CLK_READY),
      .FAULT    (FAULT),
      .RETRY_CNT(RETRY_CNT)
   );

   always #5 CLK = ~CLK;

   // Number of rising edges seen so far.
   int unsigned cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int unsigned at;
      string       name;
      logic        dcm_rst;
      logic        rst_out;
      logic        clk_ready;
      logic        fault;
      logic [3:0]  retry;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always @(negedge CLK) begin : monitor
      exp_t e;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         tests++;
         if (e.at != cyc) begin
            fails++;
            $display("FAIL %s: expectation for cycle %0d reached only at cycle %0d",
                     e.name, e.at, cyc);
         end else if ({DCM_RST, RST_OUT, CLK_READY, FAULT, RETRY_CNT} !==
                      {e.dcm_rst, e.rst_out, e.clk_ready, e.fault, e.retry}) begin
            fails++;
            $display("FAIL %s @%0d: got dcm_rst=%b rst_out=%b clk_ready=%b fault=%b retry=%0d; want dcm_rst=%b rst_out=%b clk_ready=%b fault=%b retry=%0d",
                     e.name, cyc, DCM_RST, RST_OUT, CLK_READY, FAULT, RETRY_CNT,
                     e.dcm_rst, e.rst_out, e.clk_ready, e.fault, e.retry);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) tick();
   endtask

   task automatic expect_at(input int unsigned at, input string nm, input logic d,
                            input logic r, input logic c, input logic f,
                            input logic [3:0] rc);
      exp_t e;
      e.at = at; e.name = nm; e.dcm_rst = d; e.rst_out = r; e.clk_ready = c;
      e.fault = f; e.retry = rc;
      sb.push_back(e);
   endtask

   // Output patterns per state.
   task automatic exp_rdcm(input int unsigned at, input string nm, input logic [3:0] rc);
      expect_at(at, nm, 1'b1, 1'b1, 1'b0, 1'b0, rc);
   endtask
   task automatic exp_hold(input int unsigned at, input string nm, input logic [3:0] rc);
      expect_at(at, nm, 1'b0, 1'b1, 1'b0, 1'b0, rc);
   endtask
   task automatic exp_run(input int unsigned at, input string nm);
      expect_at(at, nm, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
   endtask

   task automatic drain();
      int unsigned lim;
      lim = cyc + 300;
      while (sb.size() > 0 && cyc < lim) tick();
      if (sb.size() > 0) begin
         tests += sb.size();
         fails += sb.size();
         $display("FAIL drain: %0d expectations never checked, first %s", sb.size(),
                  sb[0].name);
         sb.delete();
      end
   endtask

   // Holds RST for 'held' edges; base is the edge count just before the first edge
   // with RST=0, so state after edge base+k is "cycle k".
   task automatic do_reset(input int unsigned held, output int unsigned base);
      drain();
      RST = 1'b1;
      exp_rdcm(cyc + 1, "in_reset", 4'd0);
      repeat (held) tick();
      RST  = 1'b0;
      base = cyc;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int unsigned b;
      int unsigned n;

      // 1: lock present throughout; release sequence of 4 + 1 + 8 cycles.
      LOCKED_IN = 1'b1;
      do_reset(3, b);
      exp_rdcm(b + 3, "s1_dcm_rst_last", 4'd0);
      exp_hold(b + 4, "s1_wait_lock", 4'd0);
      exp_hold(b + 12, "s1_stable_end", 4'd0);
      exp_run(b + 13, "s1_ready");
      exp_run(b + 20, "s1_ready_hold");

      // 2: no lock; timeouts every 24 cycles, then FAULT.
      drain();
      LOCKED_IN = 1'b0;
      do_reset(3, b);
      exp_rdcm(b + 3, "s2_rst_a1", 4'd0);
      exp_hold(b + 23, "s2_wait_end_a1", 4'd0);
      exp_rdcm(b + 24, "s2_retry1", 4'd1);
      exp_hold(b + 28, "s2_wait_a2", 4'd1);
      exp_rdcm(b + 48, "s2_retry2", 4'd2);
      exp_hold(b + 71, "s2_wait_end_a3", 4'd2);
      expect_at(b + 72, "s2_fault", 1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
      expect_at(b + 100, "s2_fault_sticky", 1'b0, 1'b1, 1'b0, 1'b1, 4'd2);

      // 3: lock drop of 3 cycles in RUN, then relock (do_reset also checks FAULT clears).
      drain();
      LOCKED_IN = 1'b1;
      do_reset(3, b);
      exp_run(b + 13, "s3_ready");
      wait_until(b + 20);
      n = cyc;
      LOCKED_IN = 1'b0;
      exp_run(n + 2, "s3_still_run");
      exp_rdcm(n + 3, "s3_loss", 4'd1);
      exp_hold(n + 15, "s3_restable", 4'd1);
      exp_run(n + 16, "s3_rerun");
      repeat (3) tick();
      LOCKED_IN = 1'b1;

      // 4: CLKFX-stopped pulse during STABLE; STATUS_IN[0] is ignored.
      drain();
      do_reset(3, b);
      exp_hold(b + 10, "s4_stable_cnt5", 4'd0);
      exp_hold(b + 12, "s4_no_ready", 4'd0);
      exp_rdcm(b + 13, "s4_flt_restart", 4'd1);
      exp_hold(b + 17, "s4_wait", 4'd1);
      exp_hold(b + 25, "s4_stable_end", 4'd1);
      exp_run(b + 26, "s4_ready");
      exp_run(b + 35, "s4_status0_a");
      exp_run(b + 40, "s4_status0_b");
      wait_until(b + 10);
      STATUS_IN = 8'h04;
      tick();
      STATUS_IN = 8'h00;
      wait_until(b + 30);
      STATUS_IN = 8'h01;
      drain();
      STATUS_IN = 8'h00;

      // 5: synchronized lock arrives in the last WAIT_LOCK cycle; lock wins.
      LOCKED_IN = 1'b0;
      do_reset(3, b);
      exp_hold(b + 23, "s5_wait_last", 4'd0);
      exp_hold(b + 24, "s5_lock_wins", 4'd0);
      exp_hold(b + 31, "s5_stable_end", 4'd0);
      exp_run(b + 32, "s5_ready");
      wait_until(b + 21);
      LOCKED_IN = 1'b1;
      drain();

      // 6: one-cycle RST while in RUN restarts the full sequence.
      do_reset(1, b);
      exp_rdcm(b + 3, "s6_dcm_rst_last", 4'd0);
      exp_hold(b + 4, "s6_wait", 4'd0);
      exp_hold(b + 12, "s6_stable_end", 4'd0);
      exp_run(b + 13, "s6_ready");
      exp_run(b + 20, "s6_ready_hold");
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
